// File: rtl/product_accumulator.sv
// product_accumulator: sums a run of `len` unsigned products from an
// upstream array multiplier and presents the total with a valid/ready
// handshake.
// The ACC_W >= M+N requirement is not enforced in the RTL itself.
// Optional build macro PRODUCT_ACCUMULATOR_SATURATE_EN: an overflowing
// addition clamps out_acc to all-ones for the rest of the run. Without it,
// out_acc wraps modulo 2^ACC_W. The overflow flag behaves the same either way.
module product_accumulator #(
    parameter int unsigned M     = 32,
    parameter int unsigned N     = 32,
    parameter int unsigned ACC_W = M + N + 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [7:0]       len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [M+N-1:0]   in_product,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [7:0]       out_count,
    output logic             overflow,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        HOLD
    } state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [7:0]       count_q, count_d;
    logic [7:0]       rem_q, rem_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W:0]   sum;
    logic             carry;

    // One-bit-wider adder so the carry out of ACC_W bits is visible.
    always_comb begin
        sum   = {1'b0, acc_q} + (ACC_W + 1)'(in_product);
        carry = sum[ACC_W];
    end

    // Next-state and datapath update for the IDLE/ACC/HOLD controller.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        rem_d   = rem_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                    rem_d   = len;
                    state_d = (len == 8'd0) ? HOLD : ACC;
                end
            end
            ACC: begin
                if (in_valid) begin
                    count_d = count_q + 8'd1;
                    rem_d   = rem_q - 8'd1;
                    if (carry) begin
                        ovf_d = 1'b1;
                    end
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
                    // Once clamped, stay clamped even if a later add is zero.
                    if (carry || ovf_q) begin
                        acc_d = '1;
                    end else begin
                        acc_d = sum[ACC_W-1:0];
                    end
`else
                    acc_d = sum[ACC_W-1:0];
`endif
                    if (rem_q == 8'd1) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            count_q <= '0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == ACC);
    assign out_valid = (state_q == HOLD);
    assign busy      = (state_q != IDLE);
    assign out_acc   = acc_q;
    assign out_count = count_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator. Two instances (ACC_W=16 and ACC_W=9) share
// one stimulus stream. A run-level model tracks the true sum and predicts
// every output of both instances each cycle. Directed sequences add
// hand-computed literal expectations.
module tb_product_accumulator;

    localparam int M = 4;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [7:0]   len;
    logic         in_valid;
    logic [M+N-1:0] in_product;
    logic         out_ready;

    logic         a_in_ready, a_out_valid, a_ovf, a_busy;
    logic [15:0]  a_acc;
    logic [7:0]   a_cnt;
    logic         b_in_ready, b_out_valid, b_ovf, b_busy;
    logic [8:0]   b_acc;
    logic [7:0]   b_cnt;

    int vectors    = 0;
    int miscompares = 0;

    product_accumulator #(.M(M), .N(N), .ACC_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_product(in_product),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_acc(a_acc),
        .out_count(a_cnt), .overflow(a_ovf), .busy(a_busy)
    );

    product_accumulator #(.M(M), .N(N), .ACC_W(9)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_product(in_product),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_acc(b_acc),
        .out_count(b_cnt), .overflow(b_ovf), .busy(b_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Visible accumulator value for a given true (unbounded) run sum.
    function automatic longint acc_of(input longint s, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
        return (s > mx) ? mx : s;
`else
        return s % (mx + 1);
`endif
    endfunction

    // Model: phase 0 = waiting for start, 1 = collecting, 2 = result offered.
    int     m_phase = 0;
    longint m_sum   = 0;
    int     m_cnt   = 0;
    int     m_len   = 0;

    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_phase = 0; m_sum = 0; m_cnt = 0; m_len = 0;
            end else if (m_phase == 0) begin
                if (start) begin
                    m_len = int'(len); m_sum = 0; m_cnt = 0;
                    m_phase = (len == 8'd0) ? 2 : 1;
                end
            end else if (m_phase == 1) begin
                if (in_valid) begin
                    m_sum += longint'(in_product);
                    m_cnt++;
                    if (m_cnt == m_len) m_phase = 2;
                end
            end else begin
                if (out_ready) m_phase = 0;
            end
            #1;
            check("a_in_ready",  a_in_ready,  m_phase == 1);
            check("a_out_valid", a_out_valid, m_phase == 2);
            check("a_busy",      a_busy,      m_phase != 0);
            check("a_out_count", a_cnt,       m_cnt);
            check("a_out_acc",   a_acc,       acc_of(m_sum, 16));
            check("a_overflow",  a_ovf,       m_sum > 65535);
            check("b_in_ready",  b_in_ready,  m_phase == 1);
            check("b_out_valid", b_out_valid, m_phase == 2);
            check("b_busy",      b_busy,      m_phase != 0);
            check("b_out_count", b_cnt,       m_cnt);
            check("b_out_acc",   b_acc,       acc_of(m_sum, 9));
            check("b_overflow",  b_ovf,       m_sum > 511);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check_zero_outputs(input string tag);
        check({tag, "_a_in_ready"},  a_in_ready,  0);
        check({tag, "_a_out_valid"}, a_out_valid, 0);
        check({tag, "_a_busy"},      a_busy,      0);
        check({tag, "_a_ovf"},       a_ovf,       0);
        check({tag, "_a_acc"},       a_acc,       0);
        check({tag, "_a_cnt"},       a_cnt,       0);
        check({tag, "_b_out_valid"}, b_out_valid, 0);
        check({tag, "_b_acc"},       b_acc,       0);
        check({tag, "_b_ovf"},       b_ovf,       0);
    endtask

    initial begin
        rst_n = 1'b1; start = 1'b0; len = 8'd0; in_valid = 1'b0;
        in_product = '0; out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_zero_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // len=3, products 10, 20, 30 back-to-back
        @(negedge clk); start = 1'b1; len = 8'd3;
        @(negedge clk); start = 1'b0; in_valid = 1'b1; in_product = 8'd10;
        check("r3_in_ready", a_in_ready, 1);
        @(negedge clk); in_product = 8'd20;
        @(negedge clk); in_product = 8'd30;
        @(negedge clk); in_valid = 1'b0;
        check("r3_out_valid", a_out_valid, 1);
        check("r3_acc", a_acc, 60);
        check("r3_cnt", a_cnt, 3);
        check("r3_ovf", a_ovf, 0);
        out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0;
        check("r3_idle_valid", a_out_valid, 0);
        check("r3_idle_acc_kept", a_acc, 60);

        // len=0 goes straight to HOLD with a zero result
        start = 1'b1; len = 8'd0;
        @(negedge clk); start = 1'b0;
        check("r0_out_valid", a_out_valid, 1);
        check("r0_acc", a_acc, 0);
        check("r0_cnt", a_cnt, 0);
        check("r0_in_ready", a_in_ready, 0);
        out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0;

        // len=2 with in_valid gaps, then a long HOLD with start/in_valid noise
        start = 1'b1; len = 8'd2;
        @(negedge clk); start = 1'b0; in_valid = 1'b1; in_product = 8'd5;
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk);
        check("gap_acc", a_acc, 5);
        check("gap_cnt", a_cnt, 1);
        check("gap_in_ready", a_in_ready, 1);
        in_valid = 1'b1; in_product = 8'd9;
        @(negedge clk); in_product = 8'd15; start = 1'b1; len = 8'd7;
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", a_out_valid, 1);
            check("hold_acc", a_acc, 14);
            check("hold_cnt", a_cnt, 2);
            check("hold_in_ready", a_in_ready, 0);
            @(negedge clk);
        end
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0;
        check("hold_exit_valid", a_out_valid, 0);
        check("hold_exit_busy", a_busy, 0);
        check("hold_exit_acc", a_acc, 14);

        // 225 x3 overflows the 9-bit instance (675 = 512 + 163)
        start = 1'b1; len = 8'd3;
        @(negedge clk); start = 1'b0; in_valid = 1'b1; in_product = 8'd225;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); in_valid = 1'b0;
        check("ovf_b_valid", b_out_valid, 1);
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
        check("ovf_b_acc", b_acc, 511);
`else
        check("ovf_b_acc", b_acc, 163);
`endif
        check("ovf_b_flag", b_ovf, 1);
        check("ovf_a_acc", a_acc, 675);
        check("ovf_a_flag", a_ovf, 0);
        out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0;
        check("ovf_b_flag_idle", b_ovf, 1);

        // Reset in the middle of a len=4 run, then restart immediately
        start = 1'b1; len = 8'd4;
        @(negedge clk); start = 1'b0; in_valid = 1'b1; in_product = 8'd3;
        @(negedge clk); in_product = 8'd4;
        @(negedge clk); in_valid = 1'b0;
        rst_n = 1'b0;
        #1 check_zero_outputs("midrst");
        @(negedge clk); rst_n = 1'b1; start = 1'b1; len = 8'd1;
        @(negedge clk); start = 1'b0; in_valid = 1'b1; in_product = 8'd7;
        @(negedge clk); in_valid = 1'b0;
        check("rst_run_valid", a_out_valid, 1);
        check("rst_run_acc", a_acc, 7);
        check("rst_run_cnt", a_cnt, 1);
        out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0;

        // in_valid while idle is ignored
        in_valid = 1'b1; in_product = 8'd200;
        @(negedge clk); in_valid = 1'b0;
        check("idle_ignore_acc", a_acc, 7);

        // len=9 with a start pulse (len=2) during ACC
        start = 1'b1; len = 8'd9;
        @(negedge clk); start = 1'b0; in_valid = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            in_product = 8'(i);
            start = (i == 3);
            len = (i == 3) ? 8'd2 : 8'd9;
            if (i == 4) check("acc_start_ignored", a_in_ready, 1);
            @(negedge clk);
        end
        in_valid = 1'b0; start = 1'b0;
        check("len9_valid", a_out_valid, 1);
        check("len9_acc", a_acc, 45);
        check("len9_cnt", a_cnt, 9);
        out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
